writeback_stage: RTL and testbench

Registered, parametrised successor to the combinational writeback mux. It accepts one retiring instruction per cycle from the memory stage over a valid/ready handshake. Result sources are ALU, load data or PC+4. It waits for late load responses, formats load data by funct3 and byte offset, and suppresses writes to x0. The block sits between the memory stage and the register file, and also exposes a busy flag and a retire counter to the hazard unit and debug.

---
 rtl/cpu_pkg.sv | 26 ++
 rtl/load_formatter.sv | 50 +++++
 rtl/writeback_stage.sv | 111 +++++++++++
 tb/tb_writeback_stage.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the writeback path: result-select codes,
// load funct3 encodings and the writeback FSM state type.
package cpu_pkg;

  // Writeback result select (me_wb_sel); 2'b11 is reserved and behaves as ALU.
  localparam logic [1:0] WB_SEL_ALU = 2'b00;
  localparam logic [1:0] WB_SEL_MEM = 2'b01;
  localparam logic [1:0] WB_SEL_PC4 = 2'b10;

  // Load funct3 encodings.
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

  // Writeback FSM states.
  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_WAIT_MEM = 2'b01,
    ST_WRITE    = 2'b10
  } wb_state_e;

endpackage : cpu_pkg

// File: rtl/load_formatter.sv
// Combinational load-data formatter: selects the byte lane given by the
// address offset, then sign- or zero-extends according to funct3.
module load_formatter
  import cpu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] raw_data,
  input  logic [2:0]      funct3,
  input  logic [2:0]      offset,
  output logic [XLEN-1:0] data
);

  // On a 32-bit datapath only offset[1:0] selects a lane.
  localparam logic [2:0] LANE_MASK = (XLEN == 64) ? 3'b111 : 3'b011;

  logic [2:0]  lane;
  logic [5:0]  shift_amt;
  logic [7:0]  byte_val;
  logic [15:0] half_val;
  logic [31:0] word_val;

  // Shift the addressed lane down to bit 0; a misaligned offset simply uses
  // the lane holding the low byte of the access.
  always_comb begin
    lane      = offset & LANE_MASK;
    shift_amt = {lane, 3'b000};
    byte_val  = 8'(raw_data >> shift_amt);
    half_val  = 16'(raw_data >> shift_amt);
    word_val  = 32'(raw_data >> shift_amt);
  end

  // Extend the extracted field to XLEN according to the load type.
  always_comb begin
    // NOTE: assigning a default before the case keeps every path driven, so
    // no latch is inferred for funct3 values the case does not list.
    data = XLEN'(word_val);
    case (funct3)
      F3_LB:  data = XLEN'($signed(byte_val));
      F3_LH:  data = XLEN'($signed(half_val));
      F3_LW:  data = XLEN'($signed(word_val));
      F3_LD:  data = raw_data;
      F3_LBU: data = XLEN'(byte_val);
      F3_LHU: data = XLEN'(half_val);
      F3_LWU: data = XLEN'(word_val);
      default: data = XLEN'(word_val);
    endcase
  end

endmodule : load_formatter

// File: rtl/writeback_stage.sv
// Registered writeback stage between the memory stage and the register file.
// Accepts one retiring instruction per cycle, waits for late load responses,
// formats load data, suppresses writes to x0 and counts retirements.
module writeback_stage
  import cpu_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  me_valid,
  output logic                  me_ready,
  input  logic [XLEN-1:0]       me_alu_result,
  input  logic [XLEN-1:0]       me_pc_plus4,
  input  logic [REG_ADDR_W-1:0] me_rd,
  input  logic                  me_regwrite,
  input  logic [1:0]            me_wb_sel,
  input  logic [2:0]            me_load_funct3,
  input  logic [2:0]            me_load_offset,
  input  logic                  mem_rsp_valid,
  input  logic [XLEN-1:0]       mem_rsp_data,
  output logic [XLEN-1:0]       wb_rd_data,
  output logic [REG_ADDR_W-1:0] wb_rd_addr,
  output logic                  wb_regwrite,
  output logic                  wb_busy,
  output logic [CNT_W-1:0]      retire_count
);

  wb_state_e             state;
  logic [REG_ADDR_W-1:0] ld_rd;
  logic [2:0]            ld_funct3;
  logic [2:0]            ld_offset;
  logic                  ld_regwrite;
  logic [XLEN-1:0]       fmt_data;
  logic [XLEN-1:0]       direct_result;
  logic                  accept;
  logic                  is_mem;

  // Handshake and busy flags decode straight from the state register; ready is
  // also forced low while reset is held.
  always_comb begin
    me_ready      = reset && (state != ST_WAIT_MEM);
    wb_busy       = (state == ST_WAIT_MEM);
    accept        = me_valid && me_ready;
    is_mem        = (me_wb_sel == WB_SEL_MEM);
    direct_result = (me_wb_sel == WB_SEL_PC4) ? me_pc_plus4 : me_alu_result;
  end

  load_formatter #(
    .XLEN (XLEN)
  ) u_load_formatter (
    .raw_data (mem_rsp_data),
    .funct3   (ld_funct3),
    .offset   (ld_offset),
    .data     (fmt_data)
  );

  // Writeback FSM: registers the result, issues the one-cycle write pulse and
  // counts every cycle spent in WRITE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= ST_IDLE;
      wb_rd_data   <= '0;
      wb_rd_addr   <= '0;
      wb_regwrite  <= 1'b0;
      retire_count <= '0;
      ld_rd        <= '0;
      ld_funct3    <= '0;
      ld_offset    <= '0;
      ld_regwrite  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here so every register samples the
      // pre-edge values regardless of statement order.
      wb_regwrite <= 1'b0;
      case (state)
        ST_IDLE, ST_WRITE: begin
          if (accept) begin
            if (is_mem) begin
              ld_rd       <= me_rd;
              ld_funct3   <= me_load_funct3;
              ld_offset   <= me_load_offset;
              ld_regwrite <= me_regwrite;
              state       <= ST_WAIT_MEM;
            end else begin
              wb_rd_data   <= direct_result;
              wb_rd_addr   <= me_rd;
              wb_regwrite  <= me_regwrite && (me_rd != '0);
              retire_count <= retire_count + CNT_W'(1);
              state        <= ST_WRITE;
            end
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_WAIT_MEM: begin
          if (mem_rsp_valid) begin
            wb_rd_data   <= fmt_data;
            wb_rd_addr   <= ld_rd;
            wb_regwrite  <= ld_regwrite && (ld_rd != '0);
            retire_count <= retire_count + CNT_W'(1);
            state        <= ST_WRITE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule : writeback_stage

// File: tb/tb_writeback_stage.sv
// Directed testbench for writeback_stage (XLEN=32). A second instance with a
// 4-bit retire counter shares all inputs to exercise counter wrap.
module tb_writeback_stage;
  import cpu_pkg::*;

  logic        clk;
  logic        reset;
  logic        me_valid;
  logic        me_ready;
  logic [31:0] me_alu_result;
  logic [31:0] me_pc_plus4;
  logic [4:0]  me_rd;
  logic        me_regwrite;
  logic [1:0]  me_wb_sel;
  logic [2:0]  me_load_funct3;
  logic [2:0]  me_load_offset;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic [31:0] wb_rd_data;
  logic [4:0]  wb_rd_addr;
  logic        wb_regwrite;
  logic        wb_busy;
  logic [31:0] retire_count;

  logic        w_ready;
  logic [31:0] w_rd_data;
  logic [4:0]  w_rd_addr;
  logic        w_regwrite;
  logic        w_busy;
  logic [3:0]  w_retire_count;

  int n_checks = 0;
  int n_errors = 0;
  int exp_retire = 0;

  writeback_stage #(.XLEN(32), .REG_ADDR_W(5), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .me_valid(me_valid), .me_ready(me_ready),
    .me_alu_result(me_alu_result), .me_pc_plus4(me_pc_plus4), .me_rd(me_rd),
    .me_regwrite(me_regwrite), .me_wb_sel(me_wb_sel),
    .me_load_funct3(me_load_funct3), .me_load_offset(me_load_offset),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .wb_rd_data(wb_rd_data), .wb_rd_addr(wb_rd_addr), .wb_regwrite(wb_regwrite),
    .wb_busy(wb_busy), .retire_count(retire_count)
  );

  writeback_stage #(.XLEN(32), .REG_ADDR_W(5), .CNT_W(4)) dut_w (
    .clk(clk), .reset(reset), .me_valid(me_valid), .me_ready(w_ready),
    .me_alu_result(me_alu_result), .me_pc_plus4(me_pc_plus4), .me_rd(me_rd),
    .me_regwrite(me_regwrite), .me_wb_sel(me_wb_sel),
    .me_load_funct3(me_load_funct3), .me_load_offset(me_load_offset),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .wb_rd_data(w_rd_data), .wb_rd_addr(w_rd_addr), .wb_regwrite(w_regwrite),
    .wb_busy(w_busy), .retire_count(w_retire_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] sel, input logic [4:0] rd, input logic [31:0] alu,
                       input logic [31:0] pc4, input logic rw, input logic [2:0] f3,
                       input logic [2:0] off);
    @(negedge clk);
    me_valid       = 1'b1;
    me_wb_sel      = sel;
    me_rd          = rd;
    me_alu_result  = alu;
    me_pc_plus4    = pc4;
    me_regwrite    = rw;
    me_load_funct3 = f3;
    me_load_offset = off;
  endtask

  task automatic go_idle();
    @(negedge clk);
    me_valid = 1'b0;
  endtask

  // Non-load instruction: accepted at the next edge, written one cycle later.
  task automatic do_alu(input string tag, input logic [1:0] sel, input logic [4:0] rd,
                        input logic [31:0] alu, input logic [31:0] pc4, input logic rw,
                        input logic [31:0] exp_data, input logic exp_we);
    drive(sel, rd, alu, pc4, rw, F3_LW, 3'd0);
    check({tag, ".ready"}, 64'(me_ready), 64'd1);
    tick();
    exp_retire++;
    check({tag, ".we"},     64'(wb_regwrite),  64'(exp_we));
    check({tag, ".addr"},   64'(wb_rd_addr),   64'(rd));
    check({tag, ".data"},   64'(wb_rd_data),   64'(exp_data));
    check({tag, ".retire"}, 64'(retire_count), 64'(exp_retire));
  endtask

  // Load: accept, stall for 'stall' extra cycles, then respond.
  task automatic do_load(input string tag, input logic [2:0] f3, input logic [2:0] off,
                         input logic [4:0] rd, input logic [31:0] raw, input int stall,
                         input logic [31:0] exp_data);
    drive(WB_SEL_MEM, rd, 32'h0, 32'h0, 1'b1, f3, off);
    tick();
    @(negedge clk);
    me_valid = 1'b0;
    check({tag, ".busy0"},  64'(wb_busy),  64'd1);
    check({tag, ".ready0"}, 64'(me_ready), 64'd0);
    for (int i = 0; i < stall; i++) begin
      tick();
      check({tag, ".busy"},  64'(wb_busy),     64'd1);
      check({tag, ".ready"}, 64'(me_ready),    64'd0);
      check({tag, ".nowe"},  64'(wb_regwrite), 64'd0);
    end
    @(negedge clk);
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = raw;
    tick();
    exp_retire++;
    check({tag, ".we"},    64'(wb_regwrite), 64'd1);
    check({tag, ".addr"},  64'(wb_rd_addr),  64'(rd));
    check({tag, ".data"},  64'(wb_rd_data),  64'(exp_data));
    check({tag, ".busy1"}, 64'(wb_busy),     64'd0);
    @(negedge clk);
    mem_rsp_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    me_valid = 1'b0; me_alu_result = '0; me_pc_plus4 = '0; me_rd = '0;
    me_regwrite = 1'b0; me_wb_sel = WB_SEL_ALU; me_load_funct3 = '0;
    me_load_offset = '0; mem_rsp_valid = 1'b0; mem_rsp_data = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst.ready",  64'(me_ready),     64'd0);
    check("rst.we",     64'(wb_regwrite),  64'd0);
    check("rst.busy",   64'(wb_busy),      64'd0);
    check("rst.retire", 64'(retire_count), 64'd0);
    check("rst.data",   64'(wb_rd_data),   64'd0);
    check("rst.addr",   64'(wb_rd_addr),   64'd0);
    @(negedge clk);
    reset = 1'b1;

    // Back-to-back ALU
    do_alu("b2b1", WB_SEL_ALU, 5'd1, 32'h11, 32'h0, 1'b1, 32'h11, 1'b1);
    do_alu("b2b2", WB_SEL_ALU, 5'd2, 32'h22, 32'h0, 1'b1, 32'h22, 1'b1);
    do_alu("b2b3", WB_SEL_ALU, 5'd3, 32'h33, 32'h0, 1'b1, 32'h33, 1'b1);
    go_idle();
    tick();
    check("b2b.pulse",  64'(wb_regwrite),  64'd0);
    check("b2b.retire", 64'(retire_count), 64'd3);
    check("b2b.hold",   64'(wb_rd_data),   64'h33);

    // Load wait: LB offset 2 on 0x0080FF00
    do_load("lb", F3_LB, 3'd2, 5'd5, 32'h0080FF00, 2, 32'hFFFFFF80);

    // Extension variants on 0x8001F0F0
    do_load("lbu", F3_LBU, 3'd0, 5'd6, 32'h8001F0F0, 0, 32'h000000F0);
    do_load("lh",  F3_LH,  3'd2, 5'd7, 32'h8001F0F0, 0, 32'hFFFF8001);
    do_load("lhu", F3_LHU, 3'd2, 5'd8, 32'h8001F0F0, 1, 32'h00008001);
    do_load("lw",  F3_LW,  3'd0, 5'd9, 32'h8001F0F0, 0, 32'h8001F0F0);
    go_idle();
    tick();
    check("ld.pulse", 64'(wb_regwrite), 64'd0);

    // Stray response while idle
    @(negedge clk);
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 32'h12345678;
    tick();
    check("stray.we",     64'(wb_regwrite),  64'd0);
    check("stray.busy",   64'(wb_busy),      64'd0);
    check("stray.retire", 64'(retire_count), 64'(exp_retire));
    @(negedge clk);
    mem_rsp_valid = 1'b0;

    // x0 and PC+4, reserved select, regwrite=0
    do_alu("jal.x0", WB_SEL_PC4, 5'd0, 32'h999, 32'h104, 1'b1, 32'h104, 1'b0);
    do_alu("jal.x1", WB_SEL_PC4, 5'd1, 32'h999, 32'h104, 1'b1, 32'h104, 1'b1);
    do_alu("rsvd",   2'b11,      5'd7, 32'h77,  32'h200, 1'b1, 32'h77,  1'b1);
    do_alu("norw",   WB_SEL_ALU, 5'd8, 32'h88,  32'h0,   1'b0, 32'h88,  1'b0);
    go_idle();
    tick();

    // Reset mid-load, then stray response
    drive(WB_SEL_MEM, 5'd10, 32'h0, 32'h0, 1'b1, F3_LW, 3'd0);
    tick();
    check("mid.busy", 64'(wb_busy), 64'd1);
    @(negedge clk);
    me_valid = 1'b0;
    reset = 1'b0;
    #1;
    check("mid.rst.ready",  64'(me_ready),     64'd0);
    check("mid.rst.busy",   64'(wb_busy),      64'd0);
    check("mid.rst.retire", 64'(retire_count), 64'd0);
    exp_retire = 0;
    tick();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 32'hDEADBEEF;
    tick();
    check("mid.we",     64'(wb_regwrite),  64'd0);
    check("mid.ready",  64'(me_ready),     64'd1);
    check("mid.busy2",  64'(wb_busy),      64'd0);
    check("mid.retire", 64'(retire_count), 64'd0);
    check("mid.data",   64'(wb_rd_data),   64'd0);
    @(negedge clk);
    mem_rsp_valid = 1'b0;

    // Counter wrap on the 4-bit instance: 17 retires
    for (int i = 0; i < 17; i++) begin
      do_alu("wrap", WB_SEL_ALU, 5'((i % 31) + 1), 32'(i), 32'h0, 1'b1, 32'(i), 1'b1);
    end
    go_idle();
    tick();
    check("wrap.cnt4",  64'(w_retire_count), 64'd1);
    check("wrap.cnt32", 64'(retire_count),   64'd17);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule : tb_writeback_stage
